// File: rtl/pc_sequencer.sv
// PC register and run/step/halt control ahead of the single-cycle datapath.
// Adds breakpoint compare, sticky misalignment error and exec/retire counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Next_Addr,
  output logic [31:0] PC_Addr,
  output logic        commit,
  input  logic        start,
  input  logic        step_req,
  output logic        step_ack,
  input  logic        halt_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  output logic [1:0]  state,
  output logic        err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t st;
  logic   step_q;
  logic   exec;
  logic   mis;
  logic   step_edge;
  logic   bp_hit;

  assign exec      = (st == RUN) || (st == STEP);
  assign mis       = Next_Addr[1:0] != 2'b00;
  assign commit    = exec && !mis && !err;
  assign step_edge = step_req && !step_q;
  assign bp_hit    = bp_en && (Next_Addr == bp_addr);
  assign state     = st;

  // run-control FSM, PC load, step handshake and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      PC_Addr     <= RESET_PC;
      err         <= 1'b0;
      step_ack    <= 1'b0;
      step_q      <= 1'b0;
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      step_q   <= step_req;
      step_ack <= 1'b0;
      if (exec)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (commit)
        retired_cnt <= retired_cnt + 32'd1;
      unique case (st)
        IDLE, HALT: begin
          if (!err) begin
            if (start)
              st <= RUN;
            else if (step_edge)
              st <= STEP;
          end
        end
        RUN: begin
          if (mis) begin
            err <= 1'b1;
            st  <= HALT;
          end else if (bp_hit) begin
            PC_Addr <= Next_Addr;
            st      <= HALT;
          end else if (halt_req) begin
            PC_Addr <= Next_Addr;
            st      <= HALT;
          end else begin
            PC_Addr <= Next_Addr;
          end
        end
        STEP: begin
          if (mis) begin
            err <= 1'b1;
            st  <= HALT;
          end else begin
            PC_Addr  <= Next_Addr;
            step_ack <= 1'b1;
            st       <= HALT;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage that sits directly upstream of the single-cycle CPU datapath. It holds the architectural PC and drives it onto the datapath's instruction-address input, then loads the datapath's computed next address (PC+4, branch target or jump target) each committed cycle. A run/step/halt state machine, a breakpoint comparator and cycle/retired-instruction counters add debugger control. The top level gates the datapath's RegWrite and MemWrite with `commit`, so no architectural state changes while halted.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Next_Addr` in 32: next PC from the datapath's address output.
- `PC_Addr` out 32: registered PC, drives the datapath's instruction-address input.
- `commit` out 1: combinational; current instruction's writes take effect at the next edge.
- `start` in 1: sampled each edge; enter RUN.
- `step_req` in 1: single-step request, acted on at its rising edge.
- `step_ack` out 1: registered one-cycle pulse after a step retires.
- `halt_req` in 1: sampled in RUN; stop after the current instruction.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint address.
- `state` out 2: 2'b00 IDLE, 2'b01 RUN, 2'b10 STEP, 2'b11 HALT.
- `err` out 1: sticky misaligned-address error.
- `cycle_cnt` out 32: cycles spent in RUN or STEP.
- `retired_cnt` out 32: committed instructions.

## Operation
- Reset (async, any time, including mid-RUN): `PC_Addr`=RESET_PC, `state`=IDLE, `err`=0, `step_ack`=0, both counters 0, step edge-detect register 0.
- `exec` = (`state`==RUN or STEP). `mis` = `Next_Addr[1:0]`!=0. `commit` = `exec` and not `mis` and not `err`.
- A step edge is `step_req`=1 while the registered previous `step_req`=0.
- IDLE or HALT:
  - `err`=1: stay and ignore all requests.
  - Otherwise `start`: go to RUN. `start` has priority over a step edge.
  - Otherwise step edge: go to STEP.
  - `PC_Addr` holds.
- RUN, with priority highest first:
  1. `mis`: `PC_Addr` holds, `err`<=1, go to HALT, no commit.
  2. `bp_en` and `Next_Addr`==`bp_addr`: `PC_Addr`<=`Next_Addr`, go to HALT. The current instruction commits. The instruction at `bp_addr` has not executed.
  3. `halt_req`: `PC_Addr`<=`Next_Addr`, go to HALT, with commit.
  4. Otherwise: `PC_Addr`<=`Next_Addr`, stay in RUN.
- STEP:
  - `mis`: same as in RUN (err, HALT, no commit).
  - Otherwise: commit, `PC_Addr`<=`Next_Addr`, go to HALT, `step_ack`<=1 for exactly one cycle.
  - The breakpoint is not checked in STEP. Stepping onto `bp_addr` is allowed.
  - `start` and `halt_req` are ignored in STEP.
- Counters:
  - `cycle_cnt` +1 at every edge where `exec`=1.
  - `retired_cnt` +1 at every edge where `commit`=1.
  - Both wrap modulo 2^32. Both are cleared only by reset.
- Resuming from HALT with `start` continues from the held `PC_Addr`. There is no re-fetch and no re-execution of a committed instruction.

## Timing
- `PC_Addr`, `state`, `err`, `step_ack` and the counters are registered. `commit` is combinational from `state`, `err` and `Next_Addr`.
- `start` sampled at edge k: `state`=RUN after k. The first instruction commits at edge k+1.
- In RUN, one instruction retires per cycle. There are no bubbles.
- `halt_req` sampled at edge k in RUN: the instruction in cycle k-1..k retires, and `state`=HALT after k.
- A step edge sampled at edge k: STEP during k..k+1, commit at k+1. `step_ack`=1 during k+1..k+2, with `state`=HALT.
- A new step requires `step_req` to be low for at least one sampled edge.
- A held-high `step_req` produces exactly one step.

## Test plan
- Reset with RESET_PC=32'h40, then `start`, with the datapath running straight-line code: `PC_Addr` reads 0x40, 0x44, 0x48, 0x4C on successive cycles. After 4 edges, `retired_cnt`=4 and `cycle_cnt`=4.
- `bp_en`=1, `bp_addr`=0x10, RUN from 0, with a beq at 0x08 taken to 0x10: the HALT state is entered with `PC_Addr`=0x10 and `retired_cnt`=3. A following `start` executes 0x10.
- From HALT at 0x20, hold `step_req` high for 5 cycles: exactly one commit, `PC_Addr`=0x24, one `step_ack` pulse. Drop the request, raise it again: `PC_Addr`=0x28.
- In RUN, force `Next_Addr`=0x0000_0032: `commit`=0 that cycle, `PC_Addr` holds, `err`=1, `state`=HALT. Subsequent `start` and steps are ignored until `rst_n` is pulsed.
- Assert `rst_n`=0 asynchronously mid-RUN, between edges: all outputs return to their reset values immediately, without waiting for a clock edge.
- Preload the counters near wrap by running 2^32-2 cycles (or by forcing the registers), then run 3 cycles: `cycle_cnt` wraps to 1.
